// File: rtl/accum_bank_pkg.sv
// Shared definitions for the accumulator bank: default sizing and FSM state encoding.
package accum_bank_pkg;

   localparam int unsigned BIT_LENGTH   = 8;
   localparam int unsigned DEF_WIDTH    = 2 * BIT_LENGTH;
   localparam int unsigned DEF_CHANNELS = 4;
   localparam bit          DEF_SATURATE = 1'b1;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StDump = 1'b1
   } acc_state_e;

endpackage

// File: rtl/accum_lane.sv
// Single-channel accumulator with saturate/wrap on carry-out and a sticky overflow flag.
module accum_lane
   import accum_bank_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter bit          SATURATE = DEF_SATURATE
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             add_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] addend_i,
   input  logic             drain_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   sum_ext;

   assign sum_ext = {1'b0, acc_q} + {1'b0, addend_i};

   // Next-state: drain zeroes the lane, otherwise load or accumulate on add.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (drain_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (add_i) begin
         if (clear_i) begin
            acc_d = addend_i;
            ovf_d = 1'b0;
         end else if (sum_ext[WIDTH]) begin
            ovf_d = 1'b1;
            acc_d = SATURATE ? '1 : sum_ext[WIDTH-1:0];
         end else begin
            acc_d = sum_ext[WIDTH-1:0];
         end
      end
   end

   // Lane state register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign sum_o = acc_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/accum_bank.sv
// Bank of independent accumulators with a drain FSM that streams every channel out in order.
module accum_bank
   import accum_bank_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   parameter bit          SATURATE = DEF_SATURATE
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        add_i,
   input  logic [WIDTH-1:0]            addend_i,
   input  logic [$clog2(CHANNELS)-1:0] chan_i,
   input  logic                        clear_i,
   output logic                        in_ready_o,
   input  logic                        dump_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [$clog2(CHANNELS)-1:0] out_chan_o,
   output logic [WIDTH-1:0]            out_sum_o,
   output logic                        out_ovf_o,
   output logic                        busy_o
);

   localparam int unsigned ChanW = $clog2(CHANNELS);

   acc_state_e       state_q, state_d;
   logic [ChanW-1:0] index_q, index_d;
   logic             add_fire;
   logic             beat_fire;

   logic [WIDTH-1:0]    lane_sum [CHANNELS];
   logic [CHANNELS-1:0] lane_ovf;
   logic [CHANNELS-1:0] lane_add;
   logic [CHANNELS-1:0] lane_drain;

   assign add_fire  = add_i & (state_q == StIdle);
   assign beat_fire = (state_q == StDump) & out_ready_i;

   // Out-of-range channel numbers match no lane, so such adds are silently dropped.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      assign lane_add[g]   = add_fire & (chan_i == ChanW'(g));
      assign lane_drain[g] = beat_fire & (index_q == ChanW'(g));

      accum_lane #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_lane (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .add_i    (lane_add[g]),
         .clear_i  (clear_i),
         .addend_i (addend_i),
         .drain_i  (lane_drain[g]),
         .sum_o    (lane_sum[g]),
         .ovf_o    (lane_ovf[g])
      );
   end

   // Next-state: enter DUMP on request, step through channels on each accepted beat.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      unique case (state_q)
         StIdle: begin
            if (dump_i) begin
               state_d = StDump;
               index_d = '0;
            end
         end
         StDump: begin
            if (out_ready_i) begin
               if (index_q == ChanW'(CHANNELS - 1)) begin
                  state_d = StIdle;
                  index_d = '0;
               end else begin
                  index_d = index_q + ChanW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            index_d = '0;
         end
      endcase
   end

   // FSM state and dump index registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   // Handshake flags and output mux selecting the lane under the dump index.
   always_comb begin
      in_ready_o  = (state_q == StIdle);
      out_valid_o = (state_q == StDump);
      busy_o      = (state_q == StDump);
      out_chan_o  = index_q;
      out_sum_o   = '0;
      out_ovf_o   = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (index_q == ChanW'(i)) begin
            out_sum_o = lane_sum[i];
            out_ovf_o = lane_ovf[i];
         end
      end
   end

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: three instances (saturating 4-ch, wrapping 4-ch,
// saturating 3-ch) share stimulus; expected dump beats go through per-instance queues.
module tb_accum_bank;

   typedef struct packed {
      logic [1:0]  c;
      logic [15:0] s;
      logic        o;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        add = 1'b0;
   logic [15:0] addend = '0;
   logic [1:0]  chan = '0;
   logic        clear = 1'b0;
   logic        dump = 1'b0;
   logic        out_ready = 1'b1;

   logic [2:0]  rdy, vld, bsy, ovf;
   logic [1:0]  och  [3];
   logic [15:0] osum [3];

   int total = 0;
   int bad   = 0;

   int unsigned nch [3] = '{4, 4, 3};
   bit          sat [3] = '{1'b1, 1'b0, 1'b1};

   logic [15:0] m_acc [3][4];
   logic        m_ovf [3][4];
   int          busy_cnt [3];

   beat_t q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   accum_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1'b1)) u_sat (
      .clk_i(clk), .rst_i(rst), .add_i(add), .addend_i(addend), .chan_i(chan),
      .clear_i(clear), .in_ready_o(rdy[0]), .dump_i(dump), .out_valid_o(vld[0]),
      .out_ready_i(out_ready), .out_chan_o(och[0]), .out_sum_o(osum[0]),
      .out_ovf_o(ovf[0]), .busy_o(bsy[0])
   );

   accum_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1'b0)) u_wrap (
      .clk_i(clk), .rst_i(rst), .add_i(add), .addend_i(addend), .chan_i(chan),
      .clear_i(clear), .in_ready_o(rdy[1]), .dump_i(dump), .out_valid_o(vld[1]),
      .out_ready_i(out_ready), .out_chan_o(och[1]), .out_sum_o(osum[1]),
      .out_ovf_o(ovf[1]), .busy_o(bsy[1])
   );

   accum_bank #(.WIDTH(16), .CHANNELS(3), .SATURATE(1'b1)) u_ch3 (
      .clk_i(clk), .rst_i(rst), .add_i(add), .addend_i(addend), .chan_i(chan),
      .clear_i(clear), .in_ready_o(rdy[2]), .dump_i(dump), .out_valid_o(vld[2]),
      .out_ready_i(out_ready), .out_chan_o(och[2]), .out_sum_o(osum[2]),
      .out_ovf_o(ovf[2]), .busy_o(bsy[2])
   );

   task automatic chk(input string tag, input int d, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d: got %0h want %0h", tag, d, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int qsize(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpush(input int d, input beat_t b);
      case (d)
         0:       q0.push_back(b);
         1:       q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   task automatic mon(input int d);
      beat_t e;
      if (qsize(d) == 0) begin
         total++;
         bad++;
         $error("FAIL unexpected_beat dut%0d: got chan %0d want no beat", d, och[d]);
      end else begin
         case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         chk("beat_chan", d, 32'(och[d]), 32'(e.c));
         chk("beat_sum", d, 32'(osum[d]), 32'(e.s));
         chk("beat_ovf", d, 32'(ovf[d]), 32'(e.o));
      end
   endtask

   // Scoreboard consumer: each accepted beat is compared against the queue head.
   always @(negedge clk) begin
      if (!rst && out_ready) begin
         for (int d = 0; d < 3; d++) begin
            if (vld[d] === 1'b1) mon(d);
         end
      end
   end

   task automatic model_clear;
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < 4; c++) begin
            m_acc[d][c] = '0;
            m_ovf[d][c] = 1'b0;
         end
      end
   endtask

   task automatic model_add(input logic [1:0] c, input logic [15:0] v, input bit clr);
      logic [16:0] s;
      for (int d = 0; d < 3; d++) begin
         if (int'(c) < int'(nch[d])) begin
            if (clr) begin
               m_acc[d][c] = v;
               m_ovf[d][c] = 1'b0;
            end else begin
               s = {1'b0, m_acc[d][c]} + {1'b0, v};
               if (s[16]) begin
                  m_ovf[d][c] = 1'b1;
                  m_acc[d][c] = sat[d] ? 16'hFFFF : s[15:0];
               end else begin
                  m_acc[d][c] = s[15:0];
               end
            end
         end
      end
   endtask

   task automatic push_dump;
      beat_t b;
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < int'(nch[d]); c++) begin
            b.c = 2'(c);
            b.s = m_acc[d][c];
            b.o = m_ovf[d][c];
            qpush(d, b);
            m_acc[d][c] = '0;
            m_ovf[d][c] = 1'b0;
         end
      end
   endtask

   task automatic do_add(input logic [1:0] c, input logic [15:0] v, input bit clr);
      add = 1'b1;
      chan = c;
      addend = v;
      clear = clr;
      model_add(c, v, clr);
      tick();
      add = 1'b0;
      clear = 1'b0;
   endtask

   task automatic start_dump(input bit with_add, input logic [1:0] c, input logic [15:0] v);
      dump = 1'b1;
      if (with_add) begin
         add = 1'b1;
         chan = c;
         addend = v;
         clear = 1'b0;
         model_add(c, v, 1'b0);
      end
      push_dump();
      tick();
      dump = 1'b0;
      add = 1'b0;
   endtask

   task automatic wait_idle;
      for (int d = 0; d < 3; d++) busy_cnt[d] = 0;
      for (int k = 0; k < 40; k++) begin
         if (bsy == 3'b000) break;
         for (int d = 0; d < 3; d++) if (bsy[d]) busy_cnt[d]++;
         tick();
      end
      for (int d = 0; d < 3; d++) begin
         chk("dump_ends", d, 32'(bsy[d]), 32'd0);
         chk("queue_drained", d, 32'(qsize(d)), 32'd0);
      end
   endtask

   initial begin
      logic [15:0] held_sum;
      model_clear();

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("rst_out_valid", d, 32'(vld[d]), 32'd0);
         chk("rst_busy", d, 32'(bsy[d]), 32'd0);
         chk("rst_in_ready", d, 32'(rdy[d]), 32'd1);
      end

      // Accumulate on ch0, then full dump with out_ready held high
      out_ready = 1'b1;
      do_add(2'd0, 16'd2, 1'b0);
      do_add(2'd0, 16'd4, 1'b0);
      do_add(2'd0, 16'd1024, 1'b0);
      start_dump(1'b0, 2'd0, 16'd0);
      wait_idle();
      for (int d = 0; d < 3; d++) chk("busy_cycles", d, 32'(busy_cnt[d]), 32'(nch[d]));

      // Overflow: saturate vs wrap, sticky flag
      do_add(2'd1, 16'hFFF0, 1'b1);
      do_add(2'd1, 16'h0020, 1'b0);
      start_dump(1'b0, 2'd0, 16'd0);
      wait_idle();

      // Clear-load after overflow drops the sticky flag
      do_add(2'd1, 16'hFFF0, 1'b1);
      do_add(2'd1, 16'h0020, 1'b0);
      do_add(2'd1, 16'd5, 1'b1);
      start_dump(1'b0, 2'd0, 16'd0);
      wait_idle();

      // Back-pressure: beat 0 held stable while out_ready is low
      do_add(2'd0, 16'd7, 1'b0);
      do_add(2'd2, 16'd9, 1'b0);
      held_sum = m_acc[0][0];
      out_ready = 1'b0;
      start_dump(1'b0, 2'd0, 16'd0);
      for (int k = 0; k < 3; k++) begin
         chk("stall_valid", 0, 32'(vld[0]), 32'd1);
         chk("stall_chan", 0, 32'(och[0]), 32'd0);
         chk("stall_sum", 0, 32'(osum[0]), 32'(held_sum));
         tick();
      end
      out_ready = 1'b1;
      wait_idle();
      start_dump(1'b0, 2'd0, 16'd0);
      wait_idle();

      // Add coincident with Dump is included; Add during DUMP is refused
      start_dump(1'b1, 2'd2, 16'd600);
      add = 1'b1;
      chan = 2'd3;
      addend = 16'd1024;
      for (int d = 0; d < 3; d++) chk("dump_in_ready", d, 32'(rdy[d]), 32'd0);
      tick();
      add = 1'b0;
      wait_idle();

      // Reset after the first beat aborts the dump
      do_add(2'd0, 16'd3, 1'b0);
      do_add(2'd1, 16'd4, 1'b0);
      start_dump(1'b0, 2'd0, 16'd0);
      tick();
      rst = 1'b1;
      add = 1'b1;
      chan = 2'd2;
      addend = 16'd99;
      tick();
      rst = 1'b0;
      add = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("abort_out_valid", d, 32'(vld[d]), 32'd0);
         chk("abort_in_ready", d, 32'(rdy[d]), 32'd1);
      end
      q0.delete();
      q1.delete();
      q2.delete();
      model_clear();
      start_dump(1'b0, 2'd0, 16'd0);
      wait_idle();

      // Out-of-range channel is dropped by the 3-channel instance only
      do_add(2'd3, 16'd77, 1'b0);
      start_dump(1'b0, 2'd0, 16'd0);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
